// File: rtl/rv32i_lite_core.sv
// rv32i_lite_core: multi-cycle, non-pipelined RV32I core with one shared
// valid/ready memory port for instruction fetch and data access.
// Each instruction walks FETCH -> EXEC (-> MEM) -> FETCH; illegal or
// unsupported encodings park the core in TRAP until reset.
// Optional build macro RV_MISALIGN_TRAP_EN: when defined, misaligned LW/SW and
// LH/LHU/SH trap instead of issuing a request; when undefined the offending
// low address bits are dropped and the access proceeds.
module rv32i_lite_core #(
  parameter int          ENABLE_COUNTERS = 1,
  parameter logic [31:0] PROGADDR_RESET  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        trap,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_TRAP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] insn;
  logic [31:0] rf [0:31];
  logic [1:0]  mem_lo;
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;

  // Instruction fields
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, pc_plus4;

  assign opcode   = insn[6:0];
  assign rd       = insn[11:7];
  assign f3       = insn[14:12];
  assign rs1      = insn[19:15];
  assign rs2      = insn[24:20];
  assign f7       = insn[31:25];
  assign imm_i    = {{20{insn[31]}}, insn[31:20]};
  assign imm_s    = {{20{insn[31]}}, insn[31:25], insn[11:7]};
  assign imm_b    = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
  assign imm_u    = {insn[31:12], 12'h000};
  assign imm_j    = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
  assign rs1_val  = (rs1 == 5'd0) ? 32'h0 : rf[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'h0 : rf[rs2];
  assign pc_plus4 = pc + 32'd4;

  // Integer ALU shared by OP and OP-IMM; alt selects SUB / SRA.
  function automatic logic [31:0] alu_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] fn, input logic alt);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (fn)
      3'd0:    alu_op = alt ? (a - b) : (a + b);
      3'd1:    alu_op = a << b[4:0];
      3'd2:    alu_op = {31'h0, (sa < sb)};
      3'd3:    alu_op = {31'h0, (a < b)};
      3'd4:    alu_op = a ^ b;
      3'd5:    if (alt) alu_op = sa >>> b[4:0];
               else     alu_op = a >> b[4:0];
      3'd6:    alu_op = a | b;
      default: alu_op = a & b;
    endcase
  endfunction

  // Align the addressed lane down to bit 0 and sign/zero-extend by width.
  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] lo,
                                           input logic [2:0] fn);
    logic [31:0] s;
    s = d >> {lo, 3'b000};
    case (fn)
      3'd0:    load_ext = {{24{s[7]}}, s[7:0]};
      3'd1:    load_ext = {{16{s[15]}}, s[15:0]};
      3'd4:    load_ext = {24'h0, s[7:0]};
      3'd5:    load_ext = {16'h0, s[15:0]};
      default: load_ext = s;
    endcase
  endfunction

  logic        illegal, wb_en, take, is_load, is_store, misalign;
  logic [31:0] wb_val, next_pc, eff_addr, st_data;
  logic [3:0]  st_strb;
  logic [1:0]  acc_lo;

  // Decode and execute the latched instruction combinationally.
  always_comb begin
    illegal  = 1'b0;
    wb_en    = 1'b0;
    wb_val   = 32'h0;
    take     = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    next_pc  = pc_plus4;
    eff_addr = rs1_val + ((opcode == 7'b0100011) ? imm_s : imm_i);
    case (opcode)
      7'b0110111: begin wb_en = 1'b1; wb_val = imm_u; end
      7'b0010111: begin wb_en = 1'b1; wb_val = pc + imm_u; end
      7'b1101111: begin wb_en = 1'b1; wb_val = pc_plus4; next_pc = pc + imm_j; end
      7'b1100111: begin
        wb_en   = 1'b1;
        wb_val  = pc_plus4;
        next_pc = (rs1_val + imm_i) & ~32'd1;
        illegal = (f3 != 3'd0);
      end
      7'b1100011: begin
        case (f3)
          3'd0:    take = (rs1_val == rs2_val);
          3'd1:    take = (rs1_val != rs2_val);
          3'd4:    take = ($signed(rs1_val) <  $signed(rs2_val));
          3'd5:    take = ($signed(rs1_val) >= $signed(rs2_val));
          3'd6:    take = (rs1_val <  rs2_val);
          3'd7:    take = (rs1_val >= rs2_val);
          default: illegal = 1'b1;
        endcase
        if (take) next_pc = pc + imm_b;
      end
      7'b0000011: begin
        is_load = 1'b1;
        illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      7'b0100011: begin
        is_store = 1'b1;
        illegal  = (f3 > 3'd2);
      end
      7'b0010011: begin
        wb_en   = 1'b1;
        wb_val  = alu_op(rs1_val, imm_i, f3, (f3 == 3'd5) && f7[5]);
        illegal = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                  ((f3 == 3'd5) && ((f7 & 7'b1011111) != 7'h00));
      end
      7'b0110011: begin
        wb_en   = 1'b1;
        wb_val  = alu_op(rs1_val, rs2_val, f3, f7[5]);
        illegal = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      end
      7'b0001111: illegal = (f3 != 3'd0);
      7'b1110011: begin
        if ((ENABLE_COUNTERS != 0) && (f3 == 3'd2) && (rs1 == 5'd0)) begin
          wb_en = 1'b1;
          case (insn[31:20])
            12'hC00: wb_val = cycle_cnt[31:0];
            12'hC80: wb_val = cycle_cnt[63:32];
            12'hC02: wb_val = instret_cnt[31:0];
            12'hC82: wb_val = instret_cnt[63:32];
            default: illegal = 1'b1;
          endcase
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase

    // Byte lane for the access; half/word drop the bits they cannot use.
    case (f3[1:0])
      2'd0:    acc_lo = eff_addr[1:0];
      2'd1:    acc_lo = {eff_addr[1], 1'b0};
      default: acc_lo = 2'b00;
    endcase
    case (f3[1:0])
      2'd0:    begin st_data = {4{rs2_val[7:0]}};  st_strb = 4'b0001 << acc_lo; end
      2'd1:    begin st_data = {2{rs2_val[15:0]}}; st_strb = 4'b0011 << acc_lo; end
      default: begin st_data = rs2_val;            st_strb = 4'b1111;           end
    endcase

`ifdef RV_MISALIGN_TRAP_EN
    misalign = (is_load || is_store) &&
               (((f3[1:0] == 2'd2) && (eff_addr[1:0] != 2'b00)) ||
                ((f3[1:0] == 2'd1) && eff_addr[0]));
`else
    misalign = 1'b0;
`endif

    if (next_pc[1:0] != 2'b00) illegal = 1'b1;
    if (misalign) illegal = 1'b1;
  end

  logic        rf_we;
  logic [31:0] rf_wd;

  assign rf_we = (rd != 5'd0) &&
                 (((state == S_EXEC) && wb_en && !illegal) ||
                  ((state == S_MEM) && mem_ready && is_load));
  assign rf_wd = (state == S_MEM) ? load_ext(mem_rdata, mem_lo, f3) : wb_val;

  // Register file write port; contents are not reset, x0 is never written.
  always_ff @(posedge clk) begin
    if (rf_we) rf[rd] <= rf_wd;
  end

  // Free-running cycle counter, counting in every state including TRAP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cycle_cnt <= 64'h0;
    else         cycle_cnt <= cycle_cnt + 64'd1;
  end

  // Main control FSM with registered memory-port outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_FETCH;
      pc          <= PROGADDR_RESET;
      insn        <= 32'h0;
      mem_valid   <= 1'b0;
      mem_instr   <= 1'b0;
      mem_addr    <= 32'h0;
      mem_wdata   <= 32'h0;
      mem_wstrb   <= 4'h0;
      mem_lo      <= 2'b00;
      trap        <= 1'b0;
      instret_cnt <= 64'h0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!mem_valid) begin
            mem_valid <= 1'b1;
            mem_instr <= 1'b1;
            mem_addr  <= pc;
            mem_wstrb <= 4'h0;
          end else if (mem_ready) begin
            insn      <= mem_rdata;
            mem_valid <= 1'b0;
            mem_instr <= 1'b0;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (illegal) begin
            trap  <= 1'b1;
            state <= S_TRAP;
          end else if (is_load || is_store) begin
            mem_valid <= 1'b1;
            mem_instr <= 1'b0;
            mem_addr  <= {eff_addr[31:2], 2'b00};
            mem_wdata <= st_data;
            mem_wstrb <= is_store ? st_strb : 4'h0;
            mem_lo    <= acc_lo;
            state     <= S_MEM;
          end else begin
            pc          <= next_pc;
            instret_cnt <= instret_cnt + 64'd1;
            state       <= S_FETCH;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            mem_valid   <= 1'b0;
            mem_wstrb   <= 4'h0;
            pc          <= pc_plus4;
            instret_cnt <= instret_cnt + 64'd1;
            state       <= S_FETCH;
          end
        end
        S_TRAP: begin
          trap      <= 1'b1;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_lite_core.sv
// Directed testbench for rv32i_lite_core: small hand-assembled programs run
// against a 1 KiB word memory that answers one cycle after a request.
module tb_rv32i_lite_core;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        trap, mem_valid, mem_instr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;

  logic        trap1, valid1, instr1;
  logic        ready1 = 1'b0;
  logic [31:0] addr1, wdata1;
  logic [3:0]  wstrb1;
  logic [31:0] rdata1 = 32'hC00020F3;

  rv32i_lite_core dut (
    .clk(clk), .resetn(resetn), .trap(trap),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  rv32i_lite_core #(.ENABLE_COUNTERS(0)) dut_nocnt (
    .clk(clk), .resetn(resetn), .trap(trap1),
    .mem_valid(valid1), .mem_instr(instr1), .mem_ready(ready1),
    .mem_addr(addr1), .mem_wdata(wdata1), .mem_wstrb(wstrb1),
    .mem_rdata(rdata1)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:255];
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  logic [3:0]  wr_strb [$];
  int          fetch_cnt, fetch0_cnt, fetch1c_cnt, valid_in_trap;
  logic [31:0] last_fetch;
  logic        trap_seen;
  int          stall_left, stall_done, stall_bad;
  logic [31:0] held_addr;
  logic        held_instr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input int i, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input string tag);
    logic [31:0] oa, od;
    logic [3:0]  os;
    oa = 32'hDEAD_DEAD; od = 32'hDEAD_DEAD; os = 4'hX;
    if (i < wr_addr.size()) begin
      oa = wr_addr[i]; od = wr_data[i]; os = wr_strb[i];
    end
    check({tag, "_addr"}, oa, a);
    check({tag, "_data"}, od, d);
    check({tag, "_strb"}, {28'h0, os}, {28'h0, s});
  endtask

  // Memory responder for the main core: ready one cycle after valid,
  // optional stall on a chosen fetch, write log for checking.
  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      mem_ready = 1'b0;
    end else begin
      if (trap) trap_seen = 1'b1;
      if (trap && mem_valid) valid_in_trap++;
      if (mem_valid && mem_instr && (mem_addr == 32'h0) && (stall_left > 0)) begin
        if (stall_done == 0) begin
          held_addr = mem_addr; held_instr = mem_instr;
        end else if ((mem_addr !== held_addr) || (mem_instr !== held_instr)) begin
          stall_bad++;
        end
        stall_left--;
        stall_done++;
        mem_ready = 1'b0;
      end else if (mem_valid) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[9:2]];
        if (mem_wstrb != 4'h0) begin
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          wr_addr.push_back(mem_addr);
          wr_data.push_back(mem_wdata);
          wr_strb.push_back(mem_wstrb);
        end
        if (mem_instr) begin
          fetch_cnt++;
          last_fetch = mem_addr;
          if (mem_addr == 32'h0)  fetch0_cnt++;
          if (mem_addr == 32'h1C) fetch1c_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
      end
    end
  end

  // Responder for the counter-less core: always returns rdcycle x1.
  initial forever begin
    @(negedge clk);
    ready1 = valid1 & resetn;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input int n);
    resetn = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    wr_addr.delete(); wr_data.delete(); wr_strb.delete();
    fetch_cnt = 0; fetch0_cnt = 0; fetch1c_cnt = 0; valid_in_trap = 0;
    last_fetch = 32'h0; trap_seen = 1'b0;
    stall_left = 0; stall_done = 0; stall_bad = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[9:2]] = w;
  endtask

  task automatic trap_test(input logic [31:0] w, input string tag);
    int k;
    do_reset(3);
    put(32'h0, w);
    resetn = 1'b1;
    k = 0;
    while ((fetch_cnt == 0) && (k < 20)) begin @(negedge clk); k++; end
    check({tag, "_fetched"}, 32'(fetch_cnt), 32'd1);
    k = 0;
    while (!trap && (k < 10)) begin @(negedge clk); k++; end
    check({tag, "_lat_le2"}, 32'((k >= 1) && (k <= 2)), 32'd1);
    repeat (20) @(negedge clk);
    check({tag, "_trap"}, {31'h0, trap}, 32'd1);
    check({tag, "_valid_in_trap"}, 32'(valid_in_trap), 32'd0);
    check({tag, "_one_fetch"}, 32'(fetch_cnt), 32'd1);
  endtask

  initial begin
    int k;

    // ---- Reset and counter loop ----
    do_reset(100);
    check("rst_valid", {31'h0, mem_valid}, 32'd0);
    check("rst_trap",  {31'h0, trap}, 32'd0);
    check("rst_wstrb", {28'h0, mem_wstrb}, 32'd0);
    check("rst_addr",  mem_addr, 32'h0);
    put(32'h00, 32'h3FC00093);  // addi x1,x0,1020
    put(32'h04, 32'h0000A023);  // sw   x0,0(x1)
    put(32'h08, 32'h0000A103);  // lw   x2,0(x1)
    put(32'h0C, 32'h00110113);  // addi x2,x2,1
    put(32'h10, 32'h0020A023);  // sw   x2,0(x1)
    put(32'h14, 32'h00A00193);  // addi x3,x0,10
    put(32'h18, 32'hFE311AE3);  // bne  x2,x3,-12
    put(32'h1C, 32'h0000006F);  // jal  x0,0
    resetn = 1'b1;
    k = 0;
    while (!mem_valid && (k < 10)) begin @(negedge clk); k++; end
    check("first_req_valid", {31'h0, mem_valid}, 32'd1);
    check("first_req_addr",  mem_addr, 32'h0);
    check("first_req_instr", {31'h0, mem_instr}, 32'd1);
    check("first_req_wstrb", {28'h0, mem_wstrb}, 32'd0);
    repeat (1000) @(negedge clk);
    check("loop_nwrites", 32'(wr_addr.size()), 32'd11);
    for (int i = 0; i < 11; i++) check_wr(i, 32'h3FC, 32'(i), 4'hF, "loop_wr");
    check("loop_last_fetch", last_fetch, 32'h1C);
    check("loop_spin", 32'(fetch1c_cnt > 10), 32'd1);
    check("loop_no_trap", {31'h0, trap_seen}, 32'd0);

    // ---- Byte / half accesses, x0 write discard, misaligned word ----
    do_reset(3);
    put(32'h00, 32'h3FD00093);  // addi x1,x0,0x3FD
    put(32'h04, 32'h0A500113);  // addi x2,x0,0xA5
    put(32'h08, 32'h00208023);  // sb   x2,0(x1)
    put(32'h0C, 32'h00008183);  // lb   x3,0(x1)
    put(32'h10, 32'h0000C203);  // lbu  x4,0(x1)
    put(32'h14, 32'h10302023);  // sw   x3,0x100(x0)
    put(32'h18, 32'h10402223);  // sw   x4,0x104(x0)
    put(32'h1C, 32'h10201323);  // sh   x2,0x106(x0)
    put(32'h20, 32'h00500013);  // addi x0,x0,5
    put(32'h24, 32'h10002623);  // sw   x0,0x10C(x0)
    put(32'h28, 32'h0000A283);  // lw   x5,0(x1)   (addr 0x3FD)
    put(32'h2C, 32'h10502423);  // sw   x5,0x108(x0)
    put(32'h30, 32'h0000006F);  // jal  x0,0
    resetn = 1'b1;
    repeat (300) @(negedge clk);
    check_wr(0, 32'h3FC, 32'hA5A5A5A5, 4'b0010, "sb");
    check_wr(1, 32'h100, 32'hFFFFFFA5, 4'b1111, "lb");
    check_wr(2, 32'h104, 32'h000000A5, 4'b1111, "lbu");
    check_wr(3, 32'h104, 32'h00A500A5, 4'b1100, "sh");
    check_wr(4, 32'h10C, 32'h00000000, 4'b1111, "x0_discard");
`ifdef RV_MISALIGN_TRAP_EN
    check("misalign_trap", {31'h0, trap}, 32'd1);
    check("misalign_nwrites", 32'(wr_addr.size()), 32'd5);
`else
    check_wr(5, 32'h108, 32'h0000A500, 4'b1111, "lw_misalign");
    check("bytes_no_trap", {31'h0, trap_seen}, 32'd0);
`endif

    // ---- Fetch stall of 5 cycles ----
    do_reset(3);
    put(32'h00, 32'h00700093);  // addi x1,x0,7
    put(32'h04, 32'h10102023);  // sw   x1,0x100(x0)
    put(32'h08, 32'h0000006F);  // jal  x0,0
    stall_left = 5;
    resetn = 1'b1;
    repeat (100) @(negedge clk);
    check("stall_cycles", 32'(stall_done), 32'd5);
    check("stall_stable", 32'(stall_bad), 32'd0);
    check("stall_fetch0_once", 32'(fetch0_cnt), 32'd1);
    check("stall_nwrites", 32'(wr_addr.size()), 32'd1);
    check_wr(0, 32'h100, 32'h7, 4'hF, "stall_sw");

    // ---- Illegal instructions ----
    trap_test(32'h00000000, "ill_zero");
    trap_test(32'h00000073, "ill_ecall");
    trap_test(32'h00000363, "ill_br_misalign");

    // ---- Counters ----
    do_reset(3);
    put(32'h00, 32'hC00020F3);  // rdcycle x1
    put(32'h04, 32'h00000013);  // nop
    put(32'h08, 32'h00000013);  // nop
    put(32'h0C, 32'h00000013);  // nop
    put(32'h10, 32'h00000013);  // nop
    put(32'h14, 32'hC0002173);  // rdcycle x2
    put(32'h18, 32'h401101B3);  // sub  x3,x2,x1
    put(32'h1C, 32'h10302023);  // sw   x3,0x100(x0)
    put(32'h20, 32'hC0202273);  // rdinstret x4
    put(32'h24, 32'h10402223);  // sw   x4,0x104(x0)
    put(32'h28, 32'h0000006F);  // jal  x0,0
    resetn = 1'b1;
    repeat (300) @(negedge clk);
    check_wr(0, 32'h100, 32'd15, 4'hF, "cycle_diff");
    check_wr(1, 32'h104, 32'd8, 4'hF, "instret");
    check("cnt_no_trap", {31'h0, trap_seen}, 32'd0);
    check("nocnt_trap", {31'h0, trap1}, 32'd1);
    check("nocnt_valid", {31'h0, valid1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32i_lite_core.md
Name: rv32i_lite_core

Overview:
- Multi-cycle, non-pipelined RV32I integer core with a single shared native memory port (valid/ready) for instruction fetch and data access.
- Used as the CPU in the SoC top level.
- Executes one instruction at a time.
- Halts by asserting trap on illegal or unsupported instructions.

Parameters:
- ENABLE_COUNTERS, 1, 1 = implement 64-bit cycle/instret counters readable via RDCYCLE[H]/RDINSTRET[H]; 0 = those CSR reads are illegal.
- PROGADDR_RESET, 32'h0000_0000, PC after reset.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- trap  out  1  high once core has halted on a trap; sticky until reset.
- mem_valid  out  1  memory request active.
- mem_instr  out  1  high while request is an instruction fetch.
- mem_ready  in  1  slave completes request in the cycle it is sampled high.
- mem_addr  out  32  byte address.
- mem_wdata  out  32  store data, lane-replicated.
- mem_wstrb  out  4  byte write enables; 0 = read.
- mem_rdata  in  32  read data, valid when mem_ready=1.

Behaviour:
- Reset (resetn low, asynchronous):
  - pc=PROGADDR_RESET; state=FETCH.
  - mem_valid=0, mem_instr=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, trap=0.
  - Counters=0.
  - Register file x1..x31 not reset; x0 reads 0 always and writes to it are discarded.
  - Reset mid-transaction drops the request immediately.
- Handshake:
  - mem_valid stays high with addr/wdata/wstrb/instr stable until a rising edge with mem_ready=1.
  - mem_valid drops the following cycle; the next request issues no earlier than 1 cycle later.
  - mem_ready while mem_valid=0 is ignored.
- States:
  - FETCH: mem_valid=1, mem_instr=1, mem_addr=pc, wstrb=0. On ready, latch insn -> EXEC.
  - EXEC (1 cycle):
    - ALU/branch/jump complete; rd written; pc updated; instret++ -> FETCH.
    - Load/store: compute addr=rs1+imm -> MEM.
    - Illegal -> TRAP.
  - MEM: mem_valid=1, mem_instr=0, mem_addr={addr[31:2],2'b00}.
    - Stores: wdata replicated per width, wstrb = SB 0001<<a[1:0], SH 0011<<a[1], SW 1111.
    - On ready: loads extract and sign/zero-extend; rd written; pc+=4; instret++ -> FETCH.
  - TRAP: trap=1, mem_valid=0 forever.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR (target bit0 cleared).
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LB/LH/LW/LBU/LHU, SB/SH/SW.
  - OP-IMM and OP: ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; shift amount 5 bits.
  - FENCE = NOP.
  - SYSTEM CSRRS with rs1=x0 and csr C00/C80/C02/C82 when ENABLE_COUNTERS.
  - All other encodings, including ECALL/EBREAK, go to TRAP.
- Arithmetic: 32-bit wrap-around, no overflow flag.
- Branch/JAL target pc+imm. Taken branch to a non-word-aligned target traps.
- Counters:
  - cycle increments every clock out of reset, including in TRAP.
  - instret increments on each retired instruction.
  - 64-bit wrap-around.
- Latency:
  - ALU/branch/jump: fetch handshake + 1 EXEC cycle.
  - Load/store: fetch handshake + 1 EXEC cycle + MEM handshake.
  - With a 1-cycle-ready memory, ALU ops take 3 cycles per instruction.

Optional Feature:
- Macro RV_MISALIGN_TRAP_EN.
- Defined: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]=1, enter TRAP without issuing a memory request.
- Undefined: offending low address bits are cleared (LH/SH use addr[1]; LW/SW use addr 0) and the access proceeds, no trap.

Test Plan:
- Reset: hold resetn low 100 cycles -> mem_valid=0, trap=0. First request after release: addr 0x0, mem_instr=1, wstrb=0.
- Counter-loop program:
  - Program at 0x00..0x1C: li x1,1020; sw x0,0(x1); lw x2; addi x2,1; sw x2; li x3,10; bne x2,x3,-12; jal x0,0.
  - Memory responds with 1-cycle ready.
  - Expected: writes to 0x3FC with wdata 0,1,...,10 and wstrb=1111.
  - Then repeated fetches at 0x1C; trap stays 0 through 1000 cycles.
- Byte/half access:
  - SB of 0xA5 to 0x3FD -> wstrb=0010, wdata=0xA5A5A5A5.
  - LB at 0x3FD returns 0xFFFFFFA5; LBU at 0x3FD returns 0x000000A5.
- Handshake stall: delay mem_ready 5 cycles on a fetch -> mem_addr/mem_instr held stable, no duplicate execution.
- Illegal: instruction 0x00000000 -> trap=1 within 2 cycles after its fetch handshake; mem_valid stays 0.
- Counters:
  - ENABLE_COUNTERS=1: rdcycle twice, 5 instrs apart -> difference equals elapsed cycles.
  - ENABLE_COUNTERS=0: the same instruction traps.
